// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port controller.
// Imported by the top level and by testbenches that need the same constants.
package regfile_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at index ptr, wrapping mod N.
// Produces a one-hot grant and its index; shared by other arbiters in the core.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int unsigned PW = $clog2(N);

    logic        found;
    int unsigned idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port controller: post-reset sweep of x1..x31, then
// round-robin sharing of the single write port among NREQ writeback sources.
module regfile_wb_ctrl #(
    parameter int unsigned     NREQ     = 3,
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     AW       = 5,
    parameter logic [XLEN-1:0] INIT_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 init_done,
    output logic                 WE3,
    output logic [AW-1:0]        A3,
    output logic [XLEN-1:0]      WD3
);

    import regfile_pkg::*;

    localparam int unsigned PW = $clog2(NREQ);

    wb_state_t         state_q, state_d;
    logic [AW:0]       cnt_q;
    logic [PW-1:0]     rr_ptr;
    logic [NREQ-1:0]   gnt;
    logic [PW-1:0]     gnt_idx;
    logic              sweep_last;
    logic              hs;
    logic [AW-1:0]     addr_sel;
    logic [XLEN-1:0]   data_sel;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Counter runs one past the last register so the switch edge itself emits WE3=0.
    assign sweep_last = (cnt_q == (AW+1)'(NUM_REGS));
    assign hs         = |(req_valid & req_ready);
    assign addr_sel   = req_addr[gnt_idx*AW +: AW];
    assign data_sel   = req_data[gnt_idx*XLEN +: XLEN];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            S_INIT: begin
                if (sweep_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = gnt;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= (AW+1)'(1);
            rr_ptr    <= '0;
            WE3       <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (sweep_last) begin
                        WE3       <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        WE3   <= 1'b1;
                        A3    <= cnt_q[AW-1:0];
                        WD3   <= INIT_VAL;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (hs) begin
                        // x0 writes are accepted but never reach the array.
                        WE3    <= |addr_sel;
                        A3     <= addr_sel;
                        WD3    <= data_sel;
                        rr_ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    end else begin
                        WE3 <= 1'b0;
                    end
                end
                default: begin
                    WE3 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: scoreboard of expected write-port
// outputs plus a behavioural register file fed by WE3/A3/WD3.
module tb_regfile_wb_ctrl;

    localparam int unsigned NREQ = 3;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 init_done;
    logic                 WE3;
    logic [AW-1:0]        A3;
    logic [XLEN-1:0]      WD3;

    typedef struct {
        logic            we;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } exp_t;

    exp_t            sbq[$];
    logic [XLEN-1:0] regs [32];
    int unsigned     n_cmp;
    int unsigned     n_err;

    regfile_wb_ctrl #(
        .NREQ     (NREQ),
        .XLEN     (XLEN),
        .AW       (AW),
        .INIT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .WE3       (WE3),
        .A3        (A3),
        .WD3       (WD3)
    );

    always #5 clk = ~clk;

    // Behavioural register file: x0 is hardwired to zero, no reset.
    always @(posedge clk) begin
        if (WE3 && A3 != '0) regs[A3] <= WD3;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        req_addr[i*AW +: AW]     = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    // Drive one cycle: check ready before the edge, compare registered outputs after it.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rdy,
                         input logic we, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        exp_t e;
        req_valid = v;
        #1;
        check("req_ready", 64'(req_ready), 64'(rdy));
        e.we = we;
        e.a  = a;
        e.d  = d;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("WE3", 64'(WE3), 64'(e.we));
        check("A3",  64'(A3),  64'(e.a));
        check("WD3", 64'(WD3), 64'(e.d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hFFFF_FFFF;
        regs[0]   = '0;
        n_cmp     = 0;
        n_err     = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_WE3",       64'(WE3),       64'd0);
        check("rst_A3",        64'(A3),        64'd0);
        check("rst_WD3",       64'(WD3),       64'd0);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_ready",     64'(req_ready), 64'd0);
        rst = 1'b0;

        // Sweep with requester 0 already asking for x5 from edge 1.
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        for (int n = 1; n <= 31; n++) cycle(3'b001, 3'b000, 1'b1, AW'(n), 32'h0);
        check("init_done_pre", 64'(init_done), 64'd0);
        cycle(3'b001, 3'b000, 1'b0, 5'd31, 32'h0);
        check("init_done", 64'(init_done), 64'd1);
        for (int i = 1; i < 32; i++) check("regs_sweep", 64'(regs[i]), 64'd0);

        cycle(3'b001, 3'b001, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cycle(3'b000, 3'b000, 1'b0, 5'd5, 32'hDEAD_BEEF);
        check("regs5", 64'(regs[5]), 64'hDEAD_BEEF);

        // Lone request from 2 wraps the pointer back to 0.
        set_req(2, 5'd9, 32'h0000_0099);
        cycle(3'b100, 3'b100, 1'b1, 5'd9, 32'h0000_0099);

        // Fairness: all three valid, grants rotate 0,1,2,0,1,2.
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'h100 + i);
        for (int k = 0; k < 6; k++)
            cycle(3'b111, 3'(1 << (k % 3)), 1'b1, AW'(10 + k % 3), 32'h100 + k % 3);

        // Write to x0 is accepted but suppressed.
        set_req(1, 5'd0, 32'h0000_1234);
        cycle(3'b010, 3'b010, 1'b0, 5'd0, 32'h0000_1234);
        check("regs0", 64'(regs[0]), 64'd0);

        // Pointer now 2: a lone request from 2 brings it back to 0.
        set_req(2, 5'd9, 32'h0000_0077);
        cycle(3'b100, 3'b100, 1'b1, 5'd9, 32'h0000_0077);

        // Collision on x7: req 0 then req 1, last writer wins.
        set_req(0, 5'd7, 32'h0000_AAAA);
        set_req(1, 5'd7, 32'h0000_BBBB);
        cycle(3'b011, 3'b001, 1'b1, 5'd7, 32'h0000_AAAA);
        cycle(3'b010, 3'b010, 1'b1, 5'd7, 32'h0000_BBBB);
        cycle(3'b000, 3'b000, 1'b0, 5'd7, 32'h0000_BBBB);
        check("regs7", 64'(regs[7]), 64'h0000_BBBB);
        check("regs9", 64'(regs[9]), 64'h0000_0077);

        // Mid-run reset right after a handshake restarts the sweep.
        set_req(0, 5'd3, 32'h0000_3333);
        cycle(3'b001, 3'b001, 1'b1, 5'd3, 32'h0000_3333);
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_WE3",       64'(WE3),       64'd0);
        check("mrst_A3",        64'(A3),        64'd0);
        check("mrst_init_done", 64'(init_done), 64'd0);
        check("mrst_ready",     64'(req_ready), 64'd0);
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) cycle(3'b001, 3'b000, 1'b1, AW'(n), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
